// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: operation mode,
// FSM state encoding and the digit-counter width helper.
package serial_addsub_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bits needed to count 0..k-1, never less than one so a K=1 build
    // still has a legal counter vector.
    function automatic int cnt_width(input int k);
        int w;
        w = 1;
        while ((1 << w) < k) begin
            w++;
        end
        return w;
    endfunction

endpackage : serial_addsub_pkg

// File: rtl/serial_addsub_digit_adder.sv
// DIGIT-bit ripple of full-adder cells. Besides the digit sum and the
// carry out of the top cell it exposes the carry into the top cell, which
// the parent uses for signed-overflow detection on the final digit.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    // Ripple the carry through DIGIT full-adder cells.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out = c[DIGIT];
        c_msb = c[DIGIT-1];
    end

endmodule : digit_adder

// File: rtl/serial_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor. Operands are latched on start and
// consumed DIGIT bits per cycle, LSB first, through a registered carry.
// Subtraction runs as a + ~b + ~cin so one adder slice serves both modes.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int K     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(K);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
        $fatal(1, "serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;       // holds b' (already inverted for subtract)
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   acc_q, acc_d;   // result being assembled, LSB digit first
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]       dig_sum;
    logic                   dig_cout;
    logic                   dig_cmsb;
    logic [WIDTH+DIGIT-1:0] acc_shift;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .c_in  (carry_q),
        .sum   (dig_sum),
        .c_out (dig_cout),
        .c_msb (dig_cmsb)
    );

    // Next-state and datapath update: accept in IDLE, one digit per RUN cycle.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        acc_shift = {dig_sum, acc_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = mode_e'(mode);
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = (mode_e'(mode) == MODE_SUB) ? ~b : b;
                    carry_d = (mode_e'(mode) == MODE_SUB) ? ~cin : cin;
                    acc_d   = '0;
                end
            end
            RUN: begin
                acc_d   = acc_shift[WIDTH+DIGIT-1:DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                if (cnt_q == CNT_W'(K - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    sum_d   = acc_d;
                    cout_d  = (mode_q == MODE_SUB) ? ~dig_cout : dig_cout;
                    ovf_d   = dig_cout ^ dig_cmsb;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_ADD;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub. Two instances (DIGIT=1 and DIGIT=4)
// share one stimulus stream; each has its own acceptance model, expected
// queue and monitor that checks busy, done timing and held results.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           due;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic on the operand values.
    function automatic exp_t ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rm, input logic rc, input int due);
        exp_t r;
        int ua, ub, sa, sb, ci, u, s;
        ua = int'(ra);
        ub = int'(rb);
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        ci = int'(rc);
        u  = rm ? (ua - ub - ci) : (ua + ub + ci);
        s  = rm ? (sa - sb - ci) : (sa + sb + ci);
        r.sum  = u[W-1:0];
        r.cout = rm ? (u < 0) : (u >= (1 << W));
        r.ovf  = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
        r.due  = due;
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int D = (g == 0) ? 1 : 4;
        localparam int K = W / D;

        logic         busy, done, cout, ovf;
        logic [W-1:0] sum;

        serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .mode  (mode),
            .a     (a),
            .b     (b),
            .cin   (cin),
            .busy  (busy),
            .done  (done),
            .sum   (sum),
            .cout  (cout),
            .ovf   (ovf)
        );

        exp_t q[$];
        int   remaining = 0;
        int   cyc       = 0;
        logic rst_edge  = 1'b0;

        // Acceptance model: an operation occupies the unit for K edges.
        always @(posedge clk) begin
            cyc++;
            rst_edge = !rst_n;
            if (!rst_n) begin
                q.delete();
                remaining = 0;
            end else if (remaining > 0) begin
                remaining--;
            end else if (start) begin
                q.push_back(ref_op(a, b, mode, cin, cyc + K));
                remaining = K;
            end
        end

        logic [W-1:0] held_sum  = '0;
        logic         held_cout = 1'b0;
        logic         held_ovf  = 1'b0;

        // Monitor: sample outputs mid-cycle and compare with the scoreboard.
        always @(negedge clk) begin
            exp_t e;
            if (cyc > 0) begin
                if (rst_edge) begin
                    held_sum  = '0;
                    held_cout = 1'b0;
                    held_ovf  = 1'b0;
                end
                check($sformatf("d%0d_busy", D), 32'(busy), 32'(remaining > 0));
                if (done) begin
                    if (q.size() == 0) begin
                        check($sformatf("d%0d_spurious_done", D), 32'(done), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("d%0d_done_cycle", D), 32'(cyc), 32'(e.due));
                        held_sum  = e.sum;
                        held_cout = e.cout;
                        held_ovf  = e.ovf;
                    end
                end else if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    check($sformatf("d%0d_done_missing", D), 32'(done), 32'd1);
                    held_sum  = e.sum;
                    held_cout = e.cout;
                    held_ovf  = e.ovf;
                end
                check($sformatf("d%0d_sum", D),  32'(sum),  32'(held_sum));
                check($sformatf("d%0d_cout", D), 32'(cout), 32'(held_cout));
                check($sformatf("d%0d_ovf", D),  32'(ovf),  32'(held_ovf));
            end
        end
    end

    // Single operation with a one-cycle start pulse, then drain both units.
    task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                      input logic om, input logic oc);
        @(negedge clk);
        a     = oa;
        b     = ob;
        mode  = om;
        cin   = oc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        repeat (W + 2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases.
        op(8'h3C, 8'h05, 1'b0, 1'b0);
        op(8'h7F, 8'h01, 1'b0, 1'b0);
        op(8'hFF, 8'h00, 1'b0, 1'b1);
        op(8'h00, 8'h01, 1'b1, 1'b0);
        op(8'h80, 8'h01, 1'b1, 1'b0);
        op(8'h05, 8'h03, 1'b1, 1'b1);
        op(8'hA5, 8'h5A, 1'b0, 1'b1);

        // start held high while operands change every cycle.
        @(negedge clk);
        start = 1'b1;
        repeat (40) begin
            a    = W'($urandom);
            b    = W'($urandom);
            mode = 1'($urandom);
            cin  = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Reset during the fourth RUN cycle, then a fresh operation.
        @(negedge clk);
        a     = 8'h12;
        b     = 8'h34;
        mode  = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        op(8'h9C, 8'h2B, 1'b1, 1'b0);

        // Random traffic with random start density.
        repeat (300) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            a     = W'($urandom);
            b     = W'($urandom);
            mode  = 1'($urandom);
            cin   = 1'($urandom);
        end
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_addsub
